// File: rtl/ser_frame_scheduler.sv
// Frame scheduler in front of the three-symbol serializer: round-robin data
// arbitration, periodic SYNC and IDLE fill frames, start/eot handshake with timeout.
module ser_frame_scheduler #(
  parameter int                 NUM_CH      = 4,
  parameter int                 FRAME_W     = 27,
  parameter logic [FRAME_W-1:0] IDLE_FRAME  = {1'b1, 8'hBC, 1'b1, 8'h3C, 1'b1, 8'h3C},
  parameter logic [FRAME_W-1:0] SYNC_FRAME  = {1'b1, 8'hBC, 1'b1, 8'hBC, 1'b1, 8'hBC},
  parameter int                 SYNC_PERIOD = 64,
  parameter int                 IDLE_GAP    = 16,
  parameter int                 EOT_TIMEOUT = 1024,
  parameter int                 MIN_GAP     = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic [NUM_CH-1:0]         req_i,
  input  logic [NUM_CH*FRAME_W-1:0] frame_i,
  output logic [NUM_CH-1:0]         gnt_o,
  output logic                      ser_start_o,
  output logic [FRAME_W-1:0]        ser_data_o,
  input  logic                      ser_eot_i,
  output logic                      busy_o,
  output logic [1:0]                frame_type_o,
  output logic [2:0]                cur_ch_o,
  output logic                      err_timeout_o,
  output logic [15:0]               frames_sent_o,
  output logic [1:0]                dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam logic [1:0] TYPE_DATA = 2'b00;
  localparam logic [1:0] TYPE_IDLE = 2'b01;
  localparam logic [1:0] TYPE_SYNC = 2'b10;

  localparam int IW = $clog2(IDLE_GAP + 1);
  localparam int WW = $clog2(EOT_TIMEOUT + 1);
  localparam int GW = $clog2(MIN_GAP + 1);
  localparam int SW = $clog2(SYNC_PERIOD + 2);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_GAP - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(EOT_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(MIN_GAP - 1);
  localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_PERIOD - 1);

  state_t               r_state, w_state_d;
  logic [2:0]           r_ptr;
  logic [IW-1:0]        r_idle_cnt;
  logic [WW-1:0]        r_wait_cnt;
  logic [GW-1:0]        r_gap_cnt;
  logic [SW-1:0]        r_sync_cnt;
  logic                 r_sync_due;
  logic [NUM_CH-1:0]    r_gnt;
  logic                 r_start;
  logic [FRAME_W-1:0]   r_data;
  logic [1:0]           r_type;
  logic [2:0]           r_cur_ch;
  logic                 r_err;
  logic [15:0]          r_frames;

  logic                 w_win_found;
  logic [2:0]           w_win_ch;
  logic [NUM_CH-1:0]    w_win_onehot;
  logic [FRAME_W-1:0]   w_win_frame;
  logic                 w_sel_sync, w_sel_data, w_sel_idle, w_select;

  // Round-robin winner: lowest requester at or above the pointer, else lowest overall.
  always_comb begin
    w_win_found  = 1'b0;
    w_win_ch     = '0;
    w_win_onehot = '0;
    w_win_frame  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!w_win_found && req_i[c] && (3'(c) >= r_ptr)) begin
        w_win_found     = 1'b1;
        w_win_ch        = 3'(c);
        w_win_onehot    = '0;
        w_win_onehot[c] = 1'b1;
        w_win_frame     = frame_i[c*FRAME_W +: FRAME_W];
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (!w_win_found && req_i[c]) begin
        w_win_found     = 1'b1;
        w_win_ch        = 3'(c);
        w_win_onehot    = '0;
        w_win_onehot[c] = 1'b1;
        w_win_frame     = frame_i[c*FRAME_W +: FRAME_W];
      end
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_sel_sync = 1'b0;
    w_sel_data = 1'b0;
    w_sel_idle = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable_i) begin
          if (r_sync_due)                   w_sel_sync = 1'b1;
          else if (w_win_found)             w_sel_data = 1'b1;
          else if (r_idle_cnt == IDLE_LAST) w_sel_idle = 1'b1;
        end
        if (w_sel_sync || w_sel_data || w_sel_idle) w_state_d = S_START;
      end
      S_START: w_state_d = S_WAIT;
      S_WAIT:  if (ser_eot_i || (r_wait_cnt == WAIT_LAST)) w_state_d = S_GAP;
      S_GAP:   if (r_gap_cnt == GAP_LAST) w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
    w_select = w_sel_sync | w_sel_data | w_sel_idle;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_idle_cnt <= '0;
      r_wait_cnt <= '0;
      r_gap_cnt  <= '0;
      r_sync_cnt <= '0;
      r_sync_due <= 1'b0;
      r_gnt      <= '0;
      r_start    <= 1'b0;
      r_data     <= '0;
      r_type     <= TYPE_DATA;
      r_cur_ch   <= '0;
      r_err      <= 1'b0;
      r_frames   <= '0;
    end else begin
      r_state <= w_state_d;
      r_start <= w_select;
      r_gnt   <= '0;
      r_err   <= 1'b0;

      if (w_select) begin
        r_idle_cnt <= '0;
      end else if (r_state == S_IDLE) begin
        r_idle_cnt <= enable_i ? r_idle_cnt + 1'b1 : '0;
      end

      if (w_sel_sync) begin
        r_data     <= SYNC_FRAME;
        r_type     <= TYPE_SYNC;
        r_sync_due <= 1'b0;
      end else if (w_sel_data) begin
        r_data   <= w_win_frame;
        r_type   <= TYPE_DATA;
        r_gnt    <= w_win_onehot;
        r_cur_ch <= w_win_ch;
        r_ptr    <= (w_win_ch == 3'(NUM_CH - 1)) ? 3'd0 : w_win_ch + 3'd1;
      end else if (w_sel_idle) begin
        r_data <= IDLE_FRAME;
        r_type <= TYPE_IDLE;
      end

      if (r_state != S_WAIT) begin
        r_wait_cnt <= '0;
      end else if (ser_eot_i) begin
        r_frames <= r_frames + 16'd1;
        // Only completed data frames advance toward the next forced sync.
        if ((SYNC_PERIOD != 0) && (r_type == TYPE_DATA)) begin
          if (r_sync_cnt == SYNC_LAST) begin
            r_sync_due <= 1'b1;
            r_sync_cnt <= '0;
          end else begin
            r_sync_cnt <= r_sync_cnt + 1'b1;
          end
        end
      end else if (r_wait_cnt == WAIT_LAST) begin
        r_err <= 1'b1;
      end else begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end

      r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 1'b1 : '0;
    end
  end

  assign gnt_o         = r_gnt;
  assign ser_start_o   = r_start;
  assign ser_data_o    = r_data;
  assign busy_o        = (r_state != S_IDLE);
  assign frame_type_o  = r_type;
  assign cur_ch_o      = r_cur_ch;
  assign err_timeout_o = r_err;
  assign frames_sent_o = r_frames;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_ser_frame_scheduler.sv
// Directed bench for ser_frame_scheduler: RR grants, sync/idle insertion,
// eot timeout, and asynchronous reset in mid-frame.
module tb_ser_frame_scheduler;

  localparam int NUM_CH = 4;
  localparam int FW     = 27;
  localparam logic [FW-1:0] IDLE_F = {1'b1, 8'hBC, 1'b1, 8'h3C, 1'b1, 8'h3C};
  localparam logic [FW-1:0] SYNC_F = {1'b1, 8'hBC, 1'b1, 8'hBC, 1'b1, 8'hBC};
  localparam logic [FW-1:0] F0 = {1'b0, 8'h41, 1'b0, 8'h42, 1'b0, 8'h43};
  localparam logic [FW-1:0] F1 = {1'b0, 8'h51, 1'b0, 8'h52, 1'b0, 8'h53};
  localparam logic [FW-1:0] F2 = {1'b0, 8'h61, 1'b0, 8'h62, 1'b0, 8'h63};
  localparam logic [FW-1:0] F3 = {1'b0, 8'h71, 1'b0, 8'h72, 1'b0, 8'h73};

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 enable_i = 1'b0;
  logic [NUM_CH-1:0]    req_i = '0;
  logic [NUM_CH*FW-1:0] frame_i = '0;
  logic                 ser_eot_i = 1'b0;
  logic [NUM_CH-1:0]    gnt_o;
  logic                 ser_start_o;
  logic [FW-1:0]        ser_data_o;
  logic                 busy_o;
  logic [1:0]           frame_type_o;
  logic [2:0]           cur_ch_o;
  logic                 err_timeout_o;
  logic [15:0]          frames_sent_o;
  logic [1:0]           dbg_state_o;

  int total = 0;
  int bad   = 0;
  logic [28:0] exp_q[$];
  logic [28:0] got_q[$];
  logic [2:0]  exp_gnt_q[$];
  logic [2:0]  got_gnt_q[$];
  bit eot_auto  = 1'b0;
  int eot_delay = 1;
  int eot_cnt   = 0;

  ser_frame_scheduler #(.NUM_CH(NUM_CH), .SYNC_PERIOD(2)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .req_i(req_i),
    .frame_i(frame_i), .gnt_o(gnt_o), .ser_start_o(ser_start_o),
    .ser_data_o(ser_data_o), .ser_eot_i(ser_eot_i), .busy_o(busy_o),
    .frame_type_o(frame_type_o), .cur_ch_o(cur_ch_o),
    .err_timeout_o(err_timeout_o), .frames_sent_o(frames_sent_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"}, gnt_o, 0);
    check({tag, "_start"}, ser_start_o, 0);
    check({tag, "_data"}, ser_data_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_type"}, frame_type_o, 0);
    check({tag, "_cur_ch"}, cur_ch_o, 0);
    check({tag, "_err"}, err_timeout_o, 0);
    check({tag, "_frames"}, frames_sent_o, 0);
    check({tag, "_state"}, dbg_state_o, 0);
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    rst_ni = 1'b0; enable_i = 1'b0; req_i = '0; ser_eot_i = 1'b0;
    eot_auto = 1'b0; eot_cnt = 0;
    repeat (3) tick();
    got_q.delete(); exp_q.delete(); got_gnt_q.delete(); exp_gnt_q.delete();
    rst_ni = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy_o !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, busy_o, 0);
  endtask

  task automatic wait_frames(input string tag, input int cnt, input int budget);
    int n = 0;
    while (got_q.size() < cnt && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_frames_seen"}, got_q.size(), cnt);
  endtask

  // Serializer model: eot_delay cycles after the start pulse, one eot pulse.
  always @(posedge clk_i) begin
    #1;
    if (eot_auto) begin
      ser_eot_i = 1'b0;
      if (ser_start_o) eot_cnt = eot_delay;
      else if (eot_cnt > 0) begin
        eot_cnt--;
        if (eot_cnt == 0) ser_eot_i = 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (ser_start_o) got_q.push_back({frame_type_o, ser_data_o});
      if (gnt_o != '0) begin
        got_gnt_q.push_back(cur_ch_o);
        check("gnt_with_start", ser_start_o, 1);
        check("gnt_matches_cur_ch", gnt_o, 64'd1 << cur_ch_o);
      end
    end
  end

  task automatic compare_log(input string tag);
    check({tag, "_frame_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_frame"}, got_q.pop_front(), exp_q.pop_front());
    check({tag, "_gnt_count"}, got_gnt_q.size(), exp_gnt_q.size());
    while (exp_gnt_q.size() > 0 && got_gnt_q.size() > 0)
      check({tag, "_gnt_ch"}, got_gnt_q.pop_front(), exp_gnt_q.pop_front());
    got_q.delete(); exp_q.delete(); got_gnt_q.delete(); exp_gnt_q.delete();
  endtask

  // ---------------- tests ----------------
  initial begin
    int n;
    bit seen;

    tick();
    check_zero("por");

    // Single requester, eot 20 cycles after start.
    do_reset();
    eot_auto = 1'b1; eot_delay = 20;
    tick();
    enable_i = 1'b1; frame_i[0*FW +: FW] = F0; req_i = 4'b0001;
    tick();
    check("single_gnt", gnt_o, 4'b0001);
    check("single_start", ser_start_o, 1);
    check("single_data", ser_data_o, F0);
    check("single_type", frame_type_o, 2'b00);
    check("single_busy", busy_o, 1);
    req_i = '0;
    tick();
    check("single_start_pulse", ser_start_o, 0);
    check("single_gnt_pulse", gnt_o, 0);
    wait_idle("single", 100);
    check("single_frames_sent", frames_sent_o, 1);
    check("single_data_held", ser_data_o, F0);
    enable_i = 1'b0;

    // All four requesting, prompt eot; sync every two data frames.
    do_reset();
    eot_auto = 1'b1; eot_delay = 1;
    frame_i = {F3, F2, F1, F0};
    tick();
    enable_i = 1'b1; req_i = 4'b1111;
    wait_frames("rr", 7, 400);
    req_i = '0; enable_i = 1'b0;
    wait_idle("rr", 100);
    check("rr_frames_sent", frames_sent_o, 7);
    check("rr_cur_ch", cur_ch_o, 0);
    exp_q = '{{2'b00, F0}, {2'b00, F1}, {2'b10, SYNC_F}, {2'b00, F2},
              {2'b00, F3}, {2'b10, SYNC_F}, {2'b00, F0}};
    exp_gnt_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    compare_log("rr");

    // Channel 0 only: data, data, SYNC repeating.
    do_reset();
    eot_auto = 1'b1; eot_delay = 3;
    frame_i = '0; frame_i[0*FW +: FW] = F0;
    tick();
    enable_i = 1'b1; req_i = 4'b0001;
    wait_frames("sync", 6, 400);
    req_i = '0; enable_i = 1'b0;
    wait_idle("sync", 100);
    check("sync_frames_sent", frames_sent_o, 6);
    check("sync_last_type", frame_type_o, 2'b10);
    exp_q = '{{2'b00, F0}, {2'b00, F0}, {2'b10, SYNC_F},
              {2'b00, F0}, {2'b00, F0}, {2'b10, SYNC_F}};
    exp_gnt_q = '{3'd0, 3'd0, 3'd0, 3'd0};
    compare_log("sync");

    // No requests: IDLE fill after 16 idle cycles, repeating every 20 cycles.
    do_reset();
    eot_auto = 1'b1; eot_delay = 1;
    tick();
    enable_i = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!ser_start_o && n < 100);
    check("idle_first_delay", n, 16);
    check("idle_type", frame_type_o, 2'b01);
    check("idle_data", ser_data_o, IDLE_F);
    n = 0;
    do begin tick(); n++; end while (!ser_start_o && n < 100);
    check("idle_period", n, 20);
    enable_i = 1'b0;
    wait_idle("idle", 100);
    check("idle_frames_sent", frames_sent_o, 2);
    exp_q = '{{2'b01, IDLE_F}, {2'b01, IDLE_F}};
    compare_log("idle");

    // eot never returned: timeout pulse, frame not counted.
    do_reset();
    frame_i = {F3, F2, F1, F0};
    tick();
    enable_i = 1'b1; req_i = 4'b0010;
    tick();
    check("tmo_gnt", gnt_o, 4'b0010);
    check("tmo_start", ser_start_o, 1);
    req_i = '0;
    n = 0;
    do begin tick(); n++; end while (!err_timeout_o && n < 1100);
    check("tmo_err_delay", n, 1025);
    check("tmo_frames_sent", frames_sent_o, 0);
    check("tmo_state_gap", dbg_state_o, 2'd3);
    tick();
    check("tmo_err_pulse", err_timeout_o, 0);
    wait_idle("tmo", 20);
    check("tmo_frames_after", frames_sent_o, 0);

    // eot on the very cycle the timeout would fire: eot wins.
    req_i = 4'b0100;
    tick();
    check("tmo2_gnt", gnt_o, 4'b0100);
    req_i = '0;
    seen = 1'b0;
    for (int k = 1; k <= 1025; k++) begin
      tick();
      if (err_timeout_o) seen = 1'b1;
      if (k == 1024) ser_eot_i = 1'b1;
      if (k == 1025) ser_eot_i = 1'b0;
    end
    check("tmo2_no_err", seen, 0);
    check("tmo2_frames_sent", frames_sent_o, 1);
    check("tmo2_state_gap", dbg_state_o, 2'd3);
    enable_i = 1'b0;
    wait_idle("tmo2", 20);

    // Asynchronous reset in WAIT, then RR pointer restarts at 0.
    do_reset();
    tick();
    enable_i = 1'b1; req_i = 4'b0100;
    tick();
    check("rst_pre_gnt", gnt_o, 4'b0100);
    req_i = '0;
    tick();
    tick();
    check("rst_pre_wait", dbg_state_o, 2'd2);
    #2;
    rst_ni = 1'b0;
    #1;
    check_zero("mid_rst");
    tick();
    rst_ni = 1'b1;
    enable_i = 1'b1; req_i = 4'b1010;
    tick();
    check("post_rst_gnt", gnt_o, 4'b0010);
    check("post_rst_cur_ch", cur_ch_o, 1);
    check("post_rst_data", ser_data_o, F1);
    req_i = '0; enable_i = 1'b0;
    tick();
    ser_eot_i = 1'b1;
    tick();
    ser_eot_i = 1'b0;
    wait_idle("post_rst", 20);
    check("post_rst_frames_sent", frames_sent_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ser_frame_scheduler.md
Name: ser_frame_scheduler

Overview:
- Sequences the three-symbol serializer (27-bit frame = three 9-bit symbols {k, 8-bit}, k=1 → K-code).
- Shares the serializer between NUM_CH requesters using round-robin arbitration.
- Inserts periodic SYNC frames and IDLE fill frames, and runs the start/eot handshake with a timeout watchdog.
- Sits in the serial clock domain, directly in front of the serializer.

Parameters:
- NUM_CH, 4, number of requesters (2..8).
- FRAME_W, 27, frame width; fixed at three 9-bit symbols.
- IDLE_FRAME, 27'h1BC_1_3C_1_3C packed as {1,BC}{1,3C}{1,3C}, frame sent as idle fill.
- SYNC_FRAME, {1,BC}{1,BC}{1,BC}, frame sent as periodic sync.
- SYNC_PERIOD, 64, data frames between forced syncs; 0 disables sync.
- IDLE_GAP, 16, consecutive idle cycles with no request before an IDLE frame is sent.
- EOT_TIMEOUT, 1024, maximum cycles in WAIT before abort.
- MIN_GAP, 2, cycles held in GAP after each frame (≥1).

Ports:
- clk_i  in  1  single clock.
- rst_ni  in  1  asynchronous, active-low reset.
- enable_i  in  1  scheduler enable.
- req_i  in  NUM_CH  per-channel frame request.
- frame_i  in  NUM_CH*FRAME_W  per-channel frame; channel c at [c*27 +: 27].
- gnt_o  out  NUM_CH  one-cycle grant; the frame was taken.
- ser_start_o  out  1  one-cycle start pulse to the serializer.
- ser_data_o  out  FRAME_W  frame to the serializer.
- ser_eot_i  in  1  end-of-transmission pulse from the serializer.
- busy_o  out  1  state ≠ IDLE.
- frame_type_o  out  2  type of current/last frame: 00 data, 01 idle, 10 sync.
- cur_ch_o  out  3  channel of the last data frame.
- err_timeout_o  out  1  one-cycle pulse on EOT timeout.
- frames_sent_o  out  16  count of completed frames, wraps at 65535→0.

Behaviour:
- Reset values (async, rst_ni=0): state IDLE; every output 0; RR pointer 0; sync, idle, wait and gap counters 0.
- FSM states: IDLE, START, WAIT, GAP.
- IDLE, enable_i=0: no selection; idle counter held at 0.
- IDLE, enable_i=1, selection priority:
  1. sync_due → SYNC_FRAME.
  2. Any req_i → data from the RR winner. The winner is the first requesting channel at or after the pointer, wrapping.
  3. idle counter == IDLE_GAP-1 → IDLE_FRAME.
  4. Otherwise increment the idle counter.
- On a selection at edge n:
  - ser_data_o ← chosen frame; frame_type_o updated; state → START; idle counter cleared.
  - Data selection only: gnt_o[ch]=1 and cur_ch_o=ch during cycle n+1; RR pointer ← ch+1 mod NUM_CH.
  - Requesters must hold frame_i stable while req_i is high until granted.
- START: ser_start_o=1 for exactly one cycle; → WAIT; wait counter cleared.
- ser_data_o is held constant from START until the next selection.
- WAIT:
  - ser_eot_i=1 → GAP; frames_sent_o increments.
  - A data frame also increments the sync counter. When that counter reaches SYNC_PERIOD, sync_due is set and the counter is cleared.
  - Wait counter reaches EOT_TIMEOUT-1 without eot → err_timeout_o pulse, → GAP, frames_sent_o unchanged.
  - eot and timeout in the same cycle: eot wins, no error.
- GAP: hold MIN_GAP cycles, then → IDLE. req_i is ignored during GAP.
- Sending a SYNC frame clears sync_due when it is selected.
- ser_eot_i outside WAIT is ignored.
- enable_i deasserted mid-frame: the current frame completes through GAP, then the block stays in IDLE.
- Reset mid-frame: immediate return to reset values; ser_start_o never glitches high.
- A req_i that drops before grant is simply not selected. No grant is issued for a request that is not present at the selection edge.

Test Plan:
- Single requester: req_i=0001, frame_i[0]=27'h0_41_0_42_0_43, eot returned 20 cycles after start → gnt_o=0001 and ser_start_o together one cycle after the req edge; ser_data_o=h0_41_0_42_0_43; frames_sent_o=1; frame_type_o=00.
- All four requesting continuously with prompt eot → grant order 0,1,2,3,0; cur_ch_o follows; no channel is granted twice in a row.
- SYNC_PERIOD=2 with channel 0 always requesting → data, data, SYNC_FRAME, data, data, SYNC_FRAME; frame_type_o=10 on each sync.
- enable_i=1, no requests → IDLE_FRAME started after 16 idle cycles; the pattern repeats after each GAP.
- ser_eot_i never returned → err_timeout_o pulses 1024 cycles after the WAIT entry; state returns to IDLE after GAP; frames_sent_o unchanged. Then eot and timeout on the same cycle → no error pulse.
- rst_ni low during WAIT → all outputs 0 immediately; after release the first request is granted normally with the RR pointer at 0.
